// File: rtl/lsu_gpio_pkg.sv
// Shared constants, state types and helpers for the LSU AXI GPIO slave.
// Register map, response codes and write/read FSM encodings.
package lsu_gpio_pkg;

   localparam int IO_W = 28;

   localparam logic [31:0] WIN_SIZE = 32'd32;

   localparam logic [4:0] OFF_GPIO_OUT = 5'h00;
   localparam logic [4:0] OFF_GPIO_OE  = 5'h08;
   localparam logic [4:0] OFF_LA_OUT   = 5'h10;
   localparam logic [4:0] OFF_STATUS   = 5'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_t;

   function automatic logic in_window(
      input logic [31:0] addr,
      input logic [31:0] base
   );
      logic [31:0] diff;
      diff = addr - base;
      return diff < WIN_SIZE;
   endfunction

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_val,
      input logic [31:0] new_val,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/lsu_gpio_regfile.sv
// Byte-strobed GPIO/LA register bank with committed-write counter.
// Read mux is combinational so the read FSM can sample at AR accept.
module lsu_gpio_regfile
   import lsu_gpio_pkg::*;
(
   input  logic            clk,
   input  logic            rst_l,
   input  logic            commit,
   input  logic [4:0]      wr_off,
   input  logic [31:0]     wr_data,
   input  logic [3:0]      wr_strb,
   input  logic [4:0]      rd_off,
   output logic [IO_W-1:0] gpio_out,
   output logic [IO_W-1:0] gpio_oe,
   output logic [31:0]     la_out,
   output logic [15:0]     wr_count,
   output logic [31:0]     rd_val
);

   logic [31:0] gpio_m;
   logic [31:0] oe_m;
   logic [31:0] la_m;
   logic        hit_out;
   logic        hit_oe;
   logic        hit_la;
   logic        unused_bits;

   assign gpio_m = merge_bytes({{(32-IO_W){1'b0}}, gpio_out},
                               wr_data, wr_strb);
   assign oe_m   = merge_bytes({{(32-IO_W){1'b0}}, gpio_oe},
                               wr_data, wr_strb);
   assign la_m   = merge_bytes(la_out, wr_data, wr_strb);

   assign hit_out = wr_off[4:3] == OFF_GPIO_OUT[4:3];
   assign hit_oe  = wr_off[4:3] == OFF_GPIO_OE[4:3];
   assign hit_la  = wr_off[4:3] == OFF_LA_OUT[4:3];

   // Lane/byte bits and pad-less upper bits are not part of storage.
   assign unused_bits = ^{wr_off[2:0], rd_off[2:0],
                          gpio_m[31:IO_W], oe_m[31:IO_W]};

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         gpio_out <= '0;
         gpio_oe  <= '0;
         la_out   <= '0;
         wr_count <= '0;
      end else if (commit) begin
         wr_count <= wr_count + 16'd1;
         unique case (1'b1)
            hit_out: gpio_out <= gpio_m[IO_W-1:0];
            hit_oe:  gpio_oe  <= oe_m[IO_W-1:0];
            hit_la:  la_out   <= la_m;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (rd_off[4:3])
         OFF_GPIO_OUT[4:3]: rd_val = {{(32-IO_W){1'b0}}, gpio_out};
         OFF_GPIO_OE[4:3]:  rd_val = {{(32-IO_W){1'b0}}, gpio_oe};
         OFF_LA_OUT[4:3]:   rd_val = la_out;
         OFF_STATUS[4:3]:   rd_val = {16'h0000, wr_count};
         default:           rd_val = '0;
      endcase
   end

endmodule

// File: rtl/lsu_axi_gpio_ctrl.sv
// AXI4 slave terminating the LSU port; owns GPIO and LA output registers.
// Independent write (AW/W/B) and read (AR/R) FSMs share one register bank.
module lsu_axi_gpio_ctrl
   import lsu_gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hD000_0000,
   parameter int          ID_W      = 3
)(
   input  logic            clk,
   input  logic            rst_l,
   input  logic            awvalid,
   output logic            awready,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic            wvalid,
   output logic            wready,
   input  logic [63:0]     wdata,
   input  logic [7:0]      wstrb,
   input  logic            wlast,
   output logic            bvalid,
   input  logic            bready,
   output logic [1:0]      bresp,
   output logic [ID_W-1:0] bid,
   input  logic            arvalid,
   output logic            arready,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   output logic            rvalid,
   input  logic            rready,
   output logic [63:0]     rdata,
   output logic [1:0]      rresp,
   output logic [ID_W-1:0] rid,
   output logic            rlast,
   output logic [IO_W-1:0] gpio_out,
   output logic [IO_W-1:0] gpio_oe,
   output logic [31:0]     la_out,
   output logic            wr_pulse
);

   wr_state_t       wr_state;
   rd_state_t       rd_state;

   logic [ID_W-1:0] aw_id_q;
   logic [31:0]     aw_addr_q;
   logic [7:0]      aw_len_q;
   logic [63:0]     w_data_q;
   logic [7:0]      w_strb_q;
   logic            w_last_q;

   logic [ID_W-1:0] sel_id;
   logic [31:0]     sel_addr;
   logic [7:0]      sel_len;
   logic [63:0]     sel_data;
   logic [7:0]      sel_strb;
   logic [31:0]     lane_data;
   logic [3:0]      lane_strb;
   logic            wr_done;
   logic            wr_err;
   logic            wr_commit;

   logic [7:0]      rd_cnt;
   logic [31:0]     rd_val;
   logic [63:0]     rd_lane;
   logic            rd_err;
   logic [15:0]     wr_count;

   // Pick the AW/W source for the beat that completes the handshake.
   always_comb begin
      sel_id   = aw_id_q;
      sel_addr = aw_addr_q;
      sel_len  = aw_len_q;
      sel_data = wdata;
      sel_strb = wstrb;
      wr_done  = 1'b0;
      unique case (wr_state)
         WR_IDLE: begin
            sel_id   = awid;
            sel_addr = awaddr;
            sel_len  = awlen;
            wr_done  = awvalid && wvalid &&
                       (awlen == 8'd0 || wlast);
         end
         WR_HAVE_AW: begin
            wr_done = wvalid && (aw_len_q == 8'd0 || wlast);
         end
         WR_HAVE_W: begin
            sel_id   = awid;
            sel_addr = awaddr;
            sel_len  = awlen;
            sel_data = w_data_q;
            sel_strb = w_strb_q;
            wr_done  = awvalid && (awlen == 8'd0 || w_last_q);
         end
         default: ;
      endcase
      lane_data = sel_addr[2] ? sel_data[63:32] : sel_data[31:0];
      lane_strb = sel_addr[2] ? sel_strb[7:4] : sel_strb[3:0];
      wr_err    = !in_window(sel_addr, BASE_ADDR) ||
                  sel_addr[4:3] == OFF_STATUS[4:3] ||
                  sel_len != 8'd0;
      wr_commit = wr_done && !wr_err && (lane_strb != 4'h0);
   end

   lsu_gpio_regfile u_regs (
      .clk      (clk),
      .rst_l    (rst_l),
      .commit   (wr_commit),
      .wr_off   (sel_addr[4:0]),
      .wr_data  (lane_data),
      .wr_strb  (lane_strb),
      .rd_off   (araddr[4:0]),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .la_out   (la_out),
      .wr_count (wr_count),
      .rd_val   (rd_val)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_state  <= WR_IDLE;
         awready   <= 1'b1;
         wready    <= 1'b1;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
         bid       <= '0;
         aw_id_q   <= '0;
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         w_last_q  <= 1'b0;
         wr_pulse  <= 1'b0;
      end else begin
         wr_pulse <= wr_commit;
         if (awready && awvalid) begin
            aw_id_q   <= awid;
            aw_addr_q <= awaddr;
            aw_len_q  <= awlen;
         end
         if (wr_done) begin
            wr_state <= WR_RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= wr_err ? RESP_SLVERR : RESP_OKAY;
            bid      <= sel_id;
         end else begin
            unique case (wr_state)
               WR_IDLE: begin
                  if (awvalid) begin
                     wr_state <= WR_HAVE_AW;
                     awready  <= 1'b0;
                  end else if (wvalid) begin
                     wr_state <= WR_HAVE_W;
                     wready   <= 1'b0;
                     w_data_q <= wdata;
                     w_strb_q <= wstrb;
                     w_last_q <= wlast;
                  end
               end
               WR_HAVE_AW: ;
               // Burst whose first beat was taken early: drain the rest.
               WR_HAVE_W: begin
                  if (awvalid) begin
                     wr_state <= WR_HAVE_AW;
                     awready  <= 1'b0;
                     wready   <= 1'b1;
                  end
               end
               WR_RESP: begin
                  if (bready) begin
                     wr_state <= WR_IDLE;
                     bvalid   <= 1'b0;
                     awready  <= 1'b1;
                     wready   <= 1'b1;
                  end
               end
               default: wr_state <= WR_IDLE;
            endcase
         end
      end
   end

   assign rd_err  = !in_window(araddr, BASE_ADDR) || arlen != 8'd0;
   assign rd_lane = araddr[2] ? {rd_val, 32'h0} : {32'h0, rd_val};

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_state <= RD_IDLE;
         arready  <= 1'b1;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rresp    <= RESP_OKAY;
         rdata    <= '0;
         rid      <= '0;
         rd_cnt   <= '0;
      end else begin
         unique case (rd_state)
            RD_IDLE: begin
               if (arvalid) begin
                  rd_state <= RD_DATA;
                  arready  <= 1'b0;
                  rvalid   <= 1'b1;
                  rid      <= arid;
                  rd_cnt   <= arlen;
                  rlast    <= arlen == 8'd0;
                  rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  rdata    <= rd_err ? 64'h0 : rd_lane;
               end
            end
            RD_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rd_state <= RD_IDLE;
                     rvalid   <= 1'b0;
                     rlast    <= 1'b0;
                     arready  <= 1'b1;
                  end else begin
                     rd_cnt <= rd_cnt - 8'd1;
                     rlast  <= rd_cnt == 8'd1;
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_gpio_ctrl.sv
// Directed self-checking bench for lsu_axi_gpio_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_lsu_axi_gpio_ctrl;

   localparam logic [31:0] BASE = 32'hD000_0000;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        awvalid, awready;
   logic [2:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        wvalid, wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [2:0]  bid;
   logic        arvalid, arready;
   logic [2:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        rvalid, rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic [2:0]  rid;
   logic        rlast;
   logic [27:0] gpio_out, gpio_oe;
   logic [31:0] la_out;
   logic        wr_pulse;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_axi_gpio_ctrl #(.BASE_ADDR(BASE), .ID_W(3)) dut (
      .clk(clk), .rst_l(rst_l),
      .awvalid(awvalid), .awready(awready), .awid(awid),
      .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .arid(arid),
      .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .rresp(rresp), .rid(rid), .rlast(rlast),
      .gpio_out(gpio_out), .gpio_oe(gpio_oe), .la_out(la_out),
      .wr_pulse(wr_pulse)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aw(input logic [31:0] a, input logic [2:0] id,
                         input logic [7:0] len);
      awvalid = 1'b1; awaddr = a; awid = id; awlen = len;
   endtask

   task automatic set_w(input logic [63:0] d, input logic [7:0] s,
                        input logic last);
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
   endtask

   task automatic set_ar(input logic [31:0] a, input logic [2:0] id,
                         input logic [7:0] len);
      arvalid = 1'b1; araddr = a; arid = id; arlen = len;
   endtask

   task automatic clr();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
   endtask

   initial begin
      rst_l = 1'b0;
      awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 0;
      tick(); tick();
      rst_l = 1'b1;
      tick();

      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_arready", arready, 1);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_gpio", gpio_out, 0);
      check("rst_pulse", wr_pulse, 0);

      // AW and W together to GPIO_OUT
      set_aw(BASE, 3'd3, 8'd0);
      set_w(64'h0000_0000_0ABC_DEF1, 8'h0F, 1'b1);
      tick();
      clr();
      check("w1_bvalid", bvalid, 1);
      check("w1_bresp", bresp, 2'b00);
      check("w1_bid", bid, 3'd3);
      check("w1_gpio", gpio_out, 28'hABC_DEF1);
      check("w1_pulse", wr_pulse, 1);
      check("w1_awready", awready, 0);
      bready = 1'b1;
      tick();
      check("w1_bdone", bvalid, 0);
      check("w1_pulse_off", wr_pulse, 0);
      check("w1_awready_back", awready, 1);

      // W two cycles ahead of AW, upper lane to GPIO_OE
      set_w(64'h0000_5A5A_0000_0000, 8'h30, 1'b1);
      tick();
      clr();
      check("w2_wready_held", wready, 0);
      check("w2_awready", awready, 1);
      check("w2_no_b", bvalid, 0);
      tick();
      check("w2_wready_still", wready, 0);
      set_aw(BASE + 32'h0C, 3'd5, 8'd0);
      tick();
      clr();
      check("w2_bvalid", bvalid, 1);
      check("w2_bid", bid, 3'd5);
      check("w2_bresp", bresp, 2'b00);
      check("w2_oe", gpio_oe, 28'h5A5A);
      check("w2_pulse", wr_pulse, 1);
      tick();
      check("w2_bdone", bvalid, 0);

      // Out-of-window and STATUS writes
      set_aw(BASE + 32'h40, 3'd1, 8'd0);
      set_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      tick();
      clr();
      check("oow_bresp", bresp, 2'b10);
      check("oow_pulse", wr_pulse, 0);
      tick();
      set_aw(BASE + 32'h18, 3'd2, 8'd0);
      set_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      tick();
      clr();
      check("sts_bresp", bresp, 2'b10);
      check("sts_pulse", wr_pulse, 0);
      check("err_gpio", gpio_out, 28'hABC_DEF1);
      check("err_oe", gpio_oe, 28'h5A5A);
      tick();

      // Zero strobe in selected lane
      set_aw(BASE, 3'd4, 8'd0);
      set_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1'b1);
      tick();
      clr();
      check("zs_bresp", bresp, 2'b00);
      check("zs_pulse", wr_pulse, 0);
      check("zs_gpio", gpio_out, 28'hABC_DEF1);
      tick();

      // Four-beat burst is drained and rejected
      set_aw(BASE, 3'd2, 8'd3);
      set_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
      tick();
      awvalid = 1'b0;
      check("bu_awready", awready, 0);
      check("bu_wready1", wready, 1);
      tick();
      check("bu_wready2", wready, 1);
      check("bu_nob2", bvalid, 0);
      tick();
      check("bu_nob3", bvalid, 0);
      wlast = 1'b1;
      tick();
      clr();
      check("bu_bvalid", bvalid, 1);
      check("bu_bresp", bresp, 2'b10);
      check("bu_bid", bid, 3'd2);
      check("bu_pulse", wr_pulse, 0);
      check("bu_gpio", gpio_out, 28'hABC_DEF1);
      tick();
      check("bu_bdone", bvalid, 0);

      // LA_OUT write
      set_aw(BASE + 32'h10, 3'd6, 8'd0);
      set_w(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1);
      tick();
      clr();
      check("la_val", la_out, 32'hDEAD_BEEF);
      tick();

      // STATUS read: three committed writes so far
      set_ar(BASE + 32'h18, 3'd1, 8'd0);
      tick();
      clr();
      check("st_rvalid", rvalid, 1);
      check("st_rdata", rdata, 64'd3);
      check("st_rresp", rresp, 2'b00);
      check("st_arready", arready, 0);
      rready = 1'b1;
      tick();
      check("st_rdone", rvalid, 0);

      // LA read with back-pressure
      rready = 1'b0;
      set_ar(BASE + 32'h10, 3'd4, 8'd0);
      tick();
      clr();
      for (int i = 0; i < 3; i++) begin
         check("la_rvalid", rvalid, 1);
         check("la_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
         check("la_rlast", rlast, 1);
         check("la_rid", rid, 3'd4);
         tick();
      end
      rready = 1'b1;
      check("la_still", rvalid, 1);
      tick();
      check("la_rdone", rvalid, 0);
      check("la_arready", arready, 1);

      // Upper lane read of GPIO_OE
      set_ar(BASE + 32'h0C, 3'd0, 8'd0);
      tick();
      clr();
      check("oe_rdata", rdata, 64'h0000_5A5A_0000_0000);
      tick();

      // Two-beat read burst is rejected
      set_ar(BASE, 3'd7, 8'd1);
      tick();
      clr();
      check("rb1_rvalid", rvalid, 1);
      check("rb1_rresp", rresp, 2'b10);
      check("rb1_rlast", rlast, 0);
      check("rb1_rdata", rdata, 64'h0);
      tick();
      check("rb2_rvalid", rvalid, 1);
      check("rb2_rlast", rlast, 1);
      check("rb2_rresp", rresp, 2'b10);
      tick();
      check("rb_done", rvalid, 0);

      // Reset while waiting in WR_RESP
      bready = 1'b0;
      set_aw(BASE, 3'd1, 8'd0);
      set_w(64'h0000_0000_0123_4567, 8'h0F, 1'b1);
      tick();
      clr();
      check("rs_bvalid", bvalid, 1);
      check("rs_gpio", gpio_out, 28'h123_4567);
      #2;
      rst_l = 1'b0;
      #1;
      check("rs_bdrop", bvalid, 0);
      check("rs_gpio0", gpio_out, 0);
      check("rs_oe0", gpio_oe, 0);
      check("rs_la0", la_out, 0);
      tick();
      rst_l = 1'b1;
      tick();
      check("rs_awready", awready, 1);
      check("rs_nob", bvalid, 0);
      rready = 1'b1;
      set_ar(BASE + 32'h18, 3'd2, 8'd0);
      tick();
      clr();
      check("rs_status", rdata, 64'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
